// File: rtl/cov_reader_pkg.sv
// rtl/cov_reader_pkg.sv - shared command/state types for the coverage count reader
// Purpose: command opcodes and FSM state encoding used by cov_count_reader.
// Ports:   none (package).
package cov_reader_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_NOP     = 2'd0,
      OP_DUMP    = 2'd1,
      OP_CLEAR   = 2'd2,
      OP_SUMMARY = 2'd3
   } cov_op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DUMP    = 2'd1,
      ST_CLEAR   = 2'd2,
      ST_SUMMARY = 2'd3
   } cov_state_e;

endpackage

// File: rtl/cov_toggle_counter.sv
// rtl/cov_toggle_counter.sv - saturating toggle counter for one coverage point
// Purpose: counts changes of one coverage bit relative to its previously sampled value.
// Ports:
//   clock    in   clock, posedge
//   reset_n  in   asynchronous active-low reset
//   en_i     in   counting enable; low freezes cnt and last
//   clr_i    in   clear cnt and reload last from value_i (wins over en_i)
//   value_i  in   current coverage point value
//   cnt_o    out  toggle count, sticks at all-ones
module cov_toggle_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             value_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic             r_last;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_last <= 1'b0;
         r_cnt  <= '0;
      end else if (clr_i) begin
         // Reloading last with the live value means the cycle after a clear
         // never sees a spurious toggle.
         r_last <= value_i;
         r_cnt  <= '0;
      end else if (en_i) begin
         if ((value_i ^ r_last) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         r_last <= value_i;
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/cov_count_reader.sv
// rtl/cov_count_reader.sv - toggle-coverage counters with dump stream and covered summary
// Purpose: samples NUM_POINTS coverage bits, counts toggles per point, and on command
//          streams the counts one point per beat, clears them, or counts covered points.
// Optional feature: COV_READER_THRESH_EN adds thresh_i; covered means cnt >= thresh_i.
//                   Without it the covered threshold is fixed at 1.
// Ports:
//   clock, reset_n          clock (posedge) and asynchronous active-low reset
//   pt_value_i              coverage point values
//   cov_en_i                counting enable
//   thresh_i                covered threshold (only with COV_READER_THRESH_EN)
//   cmd_valid_i/cmd_ready_o command handshake, ready only in IDLE
//   cmd_op_i                0=NOP 1=DUMP 2=CLEAR 3=SUMMARY
//   rd_valid_o/rd_ready_i   dump beat handshake
//   rd_idx_o, rd_count_o, rd_covered_o, rd_last_o   dump beat payload
//   sum_valid_o             one-cycle pulse when sum_covered_o updates
//   sum_covered_o           number of covered points, held until next SUMMARY
module cov_count_reader
   import cov_reader_pkg::*;
#(
   parameter int NUM_POINTS = 13,
   parameter int CNT_W      = 32,
   parameter int IDX_W      = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [NUM_POINTS-1:0] pt_value_i,
   input  logic                  cov_en_i,
`ifdef COV_READER_THRESH_EN
   input  logic [CNT_W-1:0]      thresh_i,
`endif
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [OP_W-1:0]       cmd_op_i,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic [IDX_W-1:0]      rd_idx_o,
   output logic [CNT_W-1:0]      rd_count_o,
   output logic                  rd_covered_o,
   output logic                  rd_last_o,
   output logic                  sum_valid_o,
   output logic [IDX_W:0]        sum_covered_o
);

   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_POINTS - 1);

   cov_state_e       r_state;
   cov_state_e       w_state_nxt;
   cov_op_e          w_op;

   logic [CNT_W-1:0] w_cnt [NUM_POINTS];
   logic [CNT_W-1:0] w_thresh;
   logic             w_clr;
   logic             w_idx_last;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             w_hit;
   logic             w_nxt_hit;
   logic             w_beat_take;

   logic [IDX_W-1:0] r_idx;
   logic             r_rd_valid;
   logic [IDX_W-1:0] r_rd_idx;
   logic [CNT_W-1:0] r_rd_count;
   logic             r_rd_covered;
   logic             r_rd_last;
   logic             r_sum_valid;
   logic [IDX_W:0]   r_sum_covered;
   logic [IDX_W:0]   r_acc;

`ifdef COV_READER_THRESH_EN
   assign w_thresh = thresh_i;
`else
   assign w_thresh = CNT_W'(1);
`endif

   assign w_clr = (r_state == ST_CLEAR);

   genvar g;
   generate
      for (g = 0; g < NUM_POINTS; g++) begin : g_pt
         cov_toggle_counter #(
            .CNT_W (CNT_W)
         ) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .en_i    (cov_en_i),
            .clr_i   (w_clr),
            .value_i (pt_value_i[g]),
            .cnt_o   (w_cnt[g])
         );
      end
   endgenerate

   assign w_op        = cov_op_e'(cmd_op_i);
   assign w_idx_last  = (r_idx == C_LAST_IDX);
   assign w_idx_nxt   = r_idx + IDX_W'(1);
   // Covered test for the point currently indexed (summary scan) and for the
   // next dump beat; the threshold is sampled on the cycle it is used.
   assign w_hit       = (w_cnt[r_idx] >= w_thresh);
   assign w_nxt_hit   = (w_cnt[w_idx_nxt] >= w_thresh);
   assign w_beat_take = r_rd_valid && rd_ready_i;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready_o = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               case (w_op)
                  OP_DUMP:    w_state_nxt = ST_DUMP;
                  OP_CLEAR:   w_state_nxt = ST_CLEAR;
                  OP_SUMMARY: w_state_nxt = ST_SUMMARY;
                  default:    w_state_nxt = ST_IDLE;
               endcase
            end
         end
         ST_DUMP: begin
            if (w_beat_take && w_idx_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            w_state_nxt = ST_IDLE;
         end
         ST_SUMMARY: begin
            if (w_idx_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_idx         <= '0;
         r_rd_valid    <= 1'b0;
         r_rd_idx      <= '0;
         r_rd_count    <= '0;
         r_rd_covered  <= 1'b0;
         r_rd_last     <= 1'b0;
         r_sum_valid   <= 1'b0;
         r_sum_covered <= '0;
         r_acc         <= '0;
      end else begin
         r_sum_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid_i && (w_op == OP_DUMP)) begin
                  // Beat 0 is loaded on the acceptance edge.
                  r_idx        <= '0;
                  r_rd_valid   <= 1'b1;
                  r_rd_idx     <= '0;
                  r_rd_count   <= w_cnt[0];
                  r_rd_covered <= (w_cnt[0] >= w_thresh);
                  r_rd_last    <= (NUM_POINTS == 1);
               end else if (cmd_valid_i && (w_op == OP_SUMMARY)) begin
                  r_idx <= '0;
                  r_acc <= '0;
               end
            end
            ST_DUMP: begin
               if (w_beat_take) begin
                  if (w_idx_last) begin
                     r_rd_valid <= 1'b0;
                     r_rd_last  <= 1'b0;
                  end else begin
                     r_idx        <= w_idx_nxt;
                     r_rd_idx     <= w_idx_nxt;
                     r_rd_count   <= w_cnt[w_idx_nxt];
                     r_rd_covered <= w_nxt_hit;
                     r_rd_last    <= (w_idx_nxt == C_LAST_IDX);
                  end
               end
            end
            ST_SUMMARY: begin
               r_acc <= r_acc + (IDX_W+1)'(w_hit);
               if (w_idx_last) begin
                  r_sum_valid   <= 1'b1;
                  r_sum_covered <= r_acc + (IDX_W+1)'(w_hit);
               end else begin
                  r_idx <= w_idx_nxt;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign rd_valid_o    = r_rd_valid;
   assign rd_idx_o      = r_rd_idx;
   assign rd_count_o    = r_rd_count;
   assign rd_covered_o  = r_rd_covered;
   assign rd_last_o     = r_rd_last;
   assign sum_valid_o   = r_sum_valid;
   assign sum_covered_o = r_sum_covered;

endmodule

// File: tb/tb_cov_count_reader.sv
// tb/tb_cov_count_reader.sv - randomized self-checking bench for cov_count_reader
module tb_cov_count_reader;
   import cov_reader_pkg::*;

   localparam int NP = 13;
   localparam int CW = 32;
   localparam int IW = 4;
   localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [NP-1:0] pt_value;
   logic          cov_en;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic          rd_valid;
   logic          rd_ready;
   logic [IW-1:0] rd_idx;
   logic [CW-1:0] rd_count;
   logic          rd_covered;
   logic          rd_last;
   logic          sum_valid;
   logic [IW:0]   sum_covered;
`ifdef COV_READER_THRESH_EN
   logic [CW-1:0] thresh;
   logic [3:0]    s_thresh;
`endif

   logic [1:0]    s_pt;
   logic          s_en;
   logic          s_cmd_valid;
   logic          s_cmd_ready;
   logic [1:0]    s_cmd_op;
   logic          s_rd_valid;
   logic          s_rd_ready;
   logic          s_rd_idx;
   logic [3:0]    s_rd_count;
   logic          s_rd_covered;
   logic          s_rd_last;
   logic          s_sum_valid;
   logic [1:0]    s_sum_covered;

   always #5 clock = ~clock;

   cov_count_reader #(.NUM_POINTS(NP), .CNT_W(CW)) u_dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .pt_value_i    (pt_value),
      .cov_en_i      (cov_en),
`ifdef COV_READER_THRESH_EN
      .thresh_i      (thresh),
`endif
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_op_i      (cmd_op),
      .rd_valid_o    (rd_valid),
      .rd_ready_i    (rd_ready),
      .rd_idx_o      (rd_idx),
      .rd_count_o    (rd_count),
      .rd_covered_o  (rd_covered),
      .rd_last_o     (rd_last),
      .sum_valid_o   (sum_valid),
      .sum_covered_o (sum_covered)
   );

   cov_count_reader #(.NUM_POINTS(2), .CNT_W(4)) u_small (
      .clock         (clock),
      .reset_n       (reset_n),
      .pt_value_i    (s_pt),
      .cov_en_i      (s_en),
`ifdef COV_READER_THRESH_EN
      .thresh_i      (s_thresh),
`endif
      .cmd_valid_i   (s_cmd_valid),
      .cmd_ready_o   (s_cmd_ready),
      .cmd_op_i      (s_cmd_op),
      .rd_valid_o    (s_rd_valid),
      .rd_ready_i    (s_rd_ready),
      .rd_idx_o      (s_rd_idx),
      .rd_count_o    (s_rd_count),
      .rd_covered_o  (s_rd_covered),
      .rd_last_o     (s_rd_last),
      .sum_valid_o   (s_sum_valid),
      .sum_covered_o (s_sum_covered)
   );

   // Reference model: toggle counts derived directly from the sampled sequence.
   longint m_cnt  [NP];
   bit     m_last [NP];
   longint thr = 1;
   int     n_checks = 0;
   int     n_fail   = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_cnt[i]  = 0;
         m_last[i] = 1'b0;
      end
   endtask

   function automatic longint model_covered_total();
      longint n = 0;
      for (int i = 0; i < NP; i++) if (m_cnt[i] >= thr) n++;
      return n;
   endfunction

   // Apply one sample cycle (called at a negedge while the reader is idle).
   task automatic step(input logic [NP-1:0] v, input logic en);
      pt_value = v;
      cov_en   = en;
      if (en) begin
         for (int i = 0; i < NP; i++) begin
            if ((v[i] != m_last[i]) && (m_cnt[i] < MAXC)) m_cnt[i]++;
            m_last[i] = v[i];
         end
      end
      @(negedge clock);
   endtask

   task automatic issue(input logic [1:0] op);
      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      @(negedge clock);
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
   endtask

   task automatic do_clear();
      issue(OP_CLEAR);
      for (int i = 0; i < NP; i++) begin
         m_cnt[i]  = 0;
         m_last[i] = pt_value[i];
      end
      @(negedge clock);
      check("clear_back_idle", cmd_ready, 1);
   endtask

   // mode 0: always ready, 1: ready every other cycle, 2: random ready
   task automatic do_dump(input int mode);
      int k = 0;
      int cyc = 0;
      logic r;
      issue(OP_DUMP);
      while (k < NP && cyc < 400) begin
         check("rd_valid", rd_valid, 1);
         check("rd_idx", rd_idx, k);
         check("rd_count", rd_count, m_cnt[k]);
         check("rd_covered", rd_covered, (m_cnt[k] >= thr) ? 1 : 0);
         check("rd_last", rd_last, (k == NP - 1) ? 1 : 0);
         case (mode)
            0:       r = 1'b1;
            1:       r = cyc[0];
            default: r = 1'($urandom_range(0, 1));
         endcase
         rd_ready = r;
         if (r) k++;
         @(negedge clock);
         cyc++;
      end
      rd_ready = 1'b0;
      check("dump_beats_done", k, NP);
      check("dump_end_valid", rd_valid, 0);
      check("dump_end_ready", cmd_ready, 1);
   endtask

   task automatic do_summary();
      int n = 1;
      longint exp_sum = model_covered_total();
      issue(OP_SUMMARY);
      while (!sum_valid && n < 40) begin
         check("sum_no_early_pulse", sum_valid, 0);
         @(negedge clock);
         n++;
      end
      check("sum_latency", n, NP + 1);
      check("sum_covered", sum_covered, exp_sum);
      @(negedge clock);
      check("sum_pulse_one_cycle", sum_valid, 0);
      check("sum_covered_held", sum_covered, exp_sum);
      check("sum_back_idle", cmd_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [NP-1:0] m;
      longint s_exp;
      int g;
      reset_n = 1'b0;
      pt_value = '0; cov_en = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; rd_ready = 1'b0;
      s_pt = '0; s_en = 1'b0; s_cmd_valid = 1'b0; s_cmd_op = 2'd0; s_rd_ready = 1'b0;
`ifdef COV_READER_THRESH_EN
      thresh = 32'd1; s_thresh = 4'd1;
`endif
      model_reset();
      repeat (2) @(negedge clock);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_count", rd_count, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_sum_valid", sum_valid, 0);
      check("rst_sum_covered", sum_covered, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // Point 2 walks 0,1,0,1,0.
      step('0, 1'b1);
      step(NP'(1) << 2, 1'b1);
      step('0, 1'b1);
      step(NP'(1) << 2, 1'b1);
      step('0, 1'b1);
      do_dump(0);

      // NOP is taken and ignored.
      issue(OP_NOP);
      check("nop_ready", cmd_ready, 1);
      check("nop_no_beat", rd_valid, 0);

      // Random activity, then a stalled dump.
      for (int i = 0; i < 20; i++) step(NP'($urandom), 1'b1);
      do_dump(1);

      // Points 0, 5, 12 toggle once after a clear.
      do_clear();
      m = '0;
      m[0] = 1'b1; m[5] = 1'b1; m[12] = 1'b1;
      step(pt_value ^ m, 1'b1);
      do_summary();

      // Clear with all-ones held; the following all-ones cycle adds nothing.
      step('1, 1'b1);
      do_clear();
      step('1, 1'b1);
      do_dump(2);

      // Random rounds with enable gaps and random commands.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < int'($urandom_range(5, 25)); i++)
            step(NP'($urandom), ($urandom_range(0, 3) != 0));
         case ($urandom_range(0, 3))
            0:       issue(OP_NOP);
            1:       do_dump(int'($urandom_range(0, 2)));
            2:       do_clear();
            default: do_summary();
         endcase
      end
      do_dump(2);

      // Narrow counter saturation.
      s_en = 1'b1;
      s_exp = 0;
      for (int i = 0; i < 20; i++) begin
         s_pt[0] = ~s_pt[0];
         if (s_exp < 15) s_exp++;
         @(negedge clock);
      end
      check("sat_cmd_ready", s_cmd_ready, 1);
      s_cmd_valid = 1'b1; s_cmd_op = OP_DUMP; s_rd_ready = 1'b1;
      @(negedge clock);
      s_cmd_valid = 1'b0;
      check("sat_b0_valid", s_rd_valid, 1);
      check("sat_b0_idx", s_rd_idx, 0);
      check("sat_b0_count", s_rd_count, s_exp);
      check("sat_b0_covered", s_rd_covered, 1);
      check("sat_b0_last", s_rd_last, 0);
      @(negedge clock);
      check("sat_b1_idx", s_rd_idx, 1);
      check("sat_b1_count", s_rd_count, 0);
      check("sat_b1_last", s_rd_last, 1);
      @(negedge clock);
      s_rd_ready = 1'b0;
      check("sat_end_valid", s_rd_valid, 0);

      // Reset asserted while beat 5 of a dump is stalled.
      step('0, 1'b1);
      issue(OP_DUMP);
      rd_ready = 1'b1;
      g = 0;
      while (rd_idx != 5 && g < 20) begin
         @(negedge clock);
         g++;
      end
      rd_ready = 1'b0;
      check("rst_mid_reach_beat5", rd_idx, 5);
      check("rst_mid_busy", cmd_ready, 0);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_valid_async", rd_valid, 0);
      check("rst_mid_ready_async", cmd_ready, 1);
      check("rst_mid_count_async", rd_count, 0);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      check("rst_mid_sum_valid", sum_valid, 0);
      step('0, 1'b1);
      do_dump(0);

`ifdef COV_READER_THRESH_EN
      // Threshold 3: a point with 2 toggles is not covered.
      thr = 3; thresh = 32'd3;
      do_clear();
      step(NP'(14), 1'b1);
      step(NP'(8), 1'b1);
      step(NP'(0), 1'b1);
      do_dump(0);
      do_summary();
      thr = 0; thresh = 32'd0;
      do_summary();
      thr = 1; thresh = 32'd1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
